imm_extend_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the RISC-V datapath; successor to the combinational extend unit, which decodes only four formats. It covers every RV32I/RV64I immediate format plus shamt and CSR-zimm, and supports XLEN 32 or 64. It adds valid/ready handshaking, a configurable register depth, and a saturating illegal-format counter, and sits between decode and execute in the pipelined core.

---
 rtl/imm_extend_pipe.sv | 139 +++++++++++++
 tb/tb_imm_extend_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate generator covering I/S/B/J/U, shamt and CSR-zimm at XLEN 32 or 64.
// Latency: STAGES register stages (1 or 2), so a result appears STAGES cycles after its input cycle; one result per cycle when unstalled.
// Backpressure: every stage holds while outReady is low. inReady falls combinationally once all stages are full, and there is no skid buffer.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   inValid/inReady     input handshake for instr (instruction bits [31:7]) and immSrc (format select)
//   outValid/outReady   output handshake for immExt (extended immediate) and illegal (came from immSrc = 3'b111)
//   errCount            saturating count of accepted illegal selects, counted at acceptance
module imm_extend_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inValid,
   output logic            inReady,
   input  logic [24:0]     instr,
   input  logic [2:0]      immSrc,
   output logic            outValid,
   input  logic            outReady,
   output logic [XLEN-1:0] immExt,
   output logic            illegal,
   output logic [7:0]      errCount
);

   localparam logic [2:0] SEL_ILLEGAL = 3'b111;

   // All formats are built at 64 bits and truncated, so a single set of
   // concatenations serves both XLEN settings.
   function automatic logic [XLEN-1:0] gen_imm(input logic [24:0] ins, input logic [2:0] sel);
      logic [31:7] ir;
      logic [63:0] w;
      ir = ins;
      w  = '0;
      case (sel)
         3'b000:  w = {{52{ir[31]}}, ir[31:20]};
         3'b001:  w = {{52{ir[31]}}, ir[31:25], ir[11:7]};
         3'b010:  w = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         3'b011:  w = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         3'b100:  w = {{32{ir[31]}}, ir[31:12], 12'b0};
         3'b101:  w = (XLEN == 64) ? {58'b0, ir[25:20]} : {59'b0, ir[24:20]};
         3'b110:  w = {59'b0, ir[19:15]};
         default: w = '0;
      endcase
      return w[XLEN-1:0];
   endfunction

   // Source feeding the output register: the raw inputs for one stage,
   // the stage-1 registers for two.
   logic            src_vld;
   logic [24:0]     src_instr;
   logic [2:0]      src_sel;

   logic            out_vld_q;
   logic [XLEN-1:0] out_imm_q, out_imm_d;
   logic            out_ill_q, out_ill_d;
   logic            out_adv;
   logic [7:0]      err_cnt_q, err_cnt_d;
   logic            accept;

   // The output register can take new data when it is empty or its data leaves this cycle.
   assign out_adv = !out_vld_q || outReady;
   assign accept  = inValid && inReady;

   if (STAGES == 2) begin : g_two_stage
      logic        s1_vld_q;
      logic [24:0] s1_instr_q;
      logic [2:0]  s1_sel_q;

      // Stage 1 advances when empty or when its entry moves into the output register.
      assign inReady = !s1_vld_q || out_adv;

      always_ff @(posedge clk) begin
         if (reset) begin
            s1_vld_q   <= 1'b0;
            s1_instr_q <= '0;
            s1_sel_q   <= '0;
         end else if (inReady) begin
            s1_vld_q <= inValid;
            if (inValid) begin
               s1_instr_q <= instr;
               s1_sel_q   <= immSrc;
            end
         end
      end

      assign src_vld   = s1_vld_q;
      assign src_instr = s1_instr_q;
      assign src_sel   = s1_sel_q;
   end else begin : g_one_stage
      // Any value other than 2 builds the single-stage form.
      assign inReady   = out_adv;
      assign src_vld   = inValid;
      assign src_instr = instr;
      assign src_sel   = immSrc;
   end

   always_comb begin
      out_imm_d = gen_imm(src_instr, src_sel);
      out_ill_d = (src_sel == SEL_ILLEGAL);
   end

   // Data is only rewritten when a valid entry loads, so a stalled result stays put.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_vld_q <= 1'b0;
         out_imm_q <= '0;
         out_ill_q <= 1'b0;
      end else if (out_adv) begin
         out_vld_q <= src_vld;
         if (src_vld) begin
            out_imm_q <= out_imm_d;
            out_ill_q <= out_ill_d;
         end
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && (immSrc == SEL_ILLEGAL) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign outValid = out_vld_q;
   assign immExt   = out_imm_q;
   assign illegal  = out_ill_q;
   assign errCount = err_cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: instance A is XLEN=32/STAGES=1, instance B is XLEN=64/STAGES=2.
module tb_imm_extend_pipe;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: XLEN 32, one stage
   logic        a_reset, a_inValid, a_inReady, a_outValid, a_outReady, a_illegal;
   logic [24:0] a_instr;
   logic [2:0]  a_immSrc;
   logic [31:0] a_immExt;
   logic [7:0]  a_errCount;

   // Instance B: XLEN 64, two stages
   logic        b_reset, b_inValid, b_inReady, b_outValid, b_outReady, b_illegal;
   logic [24:0] b_instr;
   logic [2:0]  b_immSrc;
   logic [63:0] b_immExt;
   logic [7:0]  b_errCount;

   imm_extend_pipe #(.XLEN(32), .STAGES(1)) u_a (
      .clk(clk), .reset(a_reset), .inValid(a_inValid), .inReady(a_inReady),
      .instr(a_instr), .immSrc(a_immSrc), .outValid(a_outValid), .outReady(a_outReady),
      .immExt(a_immExt), .illegal(a_illegal), .errCount(a_errCount)
   );

   imm_extend_pipe #(.XLEN(64), .STAGES(2)) u_b (
      .clk(clk), .reset(b_reset), .inValid(b_inValid), .inReady(b_inReady),
      .instr(b_instr), .immSrc(b_immSrc), .outValid(b_outValid), .outReady(b_outReady),
      .immExt(b_immExt), .illegal(b_illegal), .errCount(b_errCount)
   );

   typedef struct {
      logic [24:0] instr;
      logic [2:0]  src;
      logic [63:0] exp64;
      logic        ill;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Independent reference: instruction bit n lives at x[n-7].
   function automatic logic [64:0] ref_imm(input logic [24:0] x, input logic [2:0] s, input bit x64);
      logic [31:7] w;
      logic [63:0] r;
      w = x;
      case (s)
         3'd0: r = 64'($signed(w[31:20]));
         3'd1: r = 64'($signed({w[31:25], w[11:7]}));
         3'd2: r = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
         3'd3: r = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
         3'd4: r = 64'($signed({w[31:12], 12'h000}));
         3'd5: r = x64 ? {58'd0, w[25:20]} : {59'd0, w[24:20]};
         3'd6: r = {59'd0, w[19:15]};
         default: r = 64'd0;
      endcase
      return {(s == 3'd7), r};
   endfunction

   vec_t        vec [8];
   logic [63:0] bp_exp [4];
   logic [64:0] qa [$];
   logic [64:0] qb [$];
   logic [64:0] e;
   logic [24:0] r_instr;
   logic [2:0]  r_src;
   int          exp_cnt;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Format table: one instruction, every select.
      for (int i = 0; i < 8; i++) begin
         vec[i].instr = 25'b1111111111000100101000110;
         vec[i].src   = 3'(i);
         vec[i].ill   = (i == 7);
      end
      vec[0].exp64 = 64'hFFFFFFFFFFFFFFFC;
      vec[1].exp64 = 64'hFFFFFFFFFFFFFFE6;
      vec[2].exp64 = 64'hFFFFFFFFFFFFF7E6;
      vec[3].exp64 = 64'hFFFFFFFFFFF4A7FC;
      vec[4].exp64 = 64'hFFFFFFFFFFC4A000;
      vec[5].exp64 = 64'h000000000000003C; // 64-bit shamt; 32-bit is 1C
      vec[6].exp64 = 64'h0000000000000009;
      vec[7].exp64 = 64'h0000000000000000;

      bp_exp[0] = 64'h0000000000000001;
      bp_exp[1] = 64'h00000000000007FF;
      bp_exp[2] = 64'hFFFFFFFFFFFFF800;
      bp_exp[3] = 64'hFFFFFFFFFFFFFABC;

      a_reset = 1; a_inValid = 0; a_outReady = 0; a_instr = '0; a_immSrc = '0;
      b_reset = 1; b_inValid = 0; b_outReady = 0; b_instr = '0; b_immSrc = '0;
      tick; tick;
      a_reset = 0; b_reset = 0;

      // ---- reset state ----
      chk("rst_a_outValid", 64'(a_outValid), 64'd0);
      chk("rst_a_immExt",   64'(a_immExt),   64'd0);
      chk("rst_a_illegal",  64'(a_illegal),  64'd0);
      chk("rst_a_errCount", 64'(a_errCount), 64'd0);
      chk("rst_a_inReady",  64'(a_inReady),  64'd1);
      chk("rst_b_outValid", 64'(b_outValid), 64'd0);
      chk("rst_b_immExt",   b_immExt,        64'd0);
      chk("rst_b_errCount", 64'(b_errCount), 64'd0);
      chk("rst_b_inReady",  64'(b_inReady),  64'd1);

      // ---- A: formats, XLEN 32, result one cycle after acceptance ----
      a_outReady = 1;
      for (int i = 0; i < 8; i++) begin
         a_instr = vec[i].instr; a_immSrc = vec[i].src; a_inValid = 1;
         #1;
         chk($sformatf("a_fmt%0d_inReady", i), 64'(a_inReady), 64'd1);
         tick;
         chk($sformatf("a_fmt%0d_outValid", i), 64'(a_outValid), 64'd1);
         chk($sformatf("a_fmt%0d_immExt", i), 64'(a_immExt),
             (i == 5) ? 64'h1C : 64'(vec[i].exp64[31:0]));
         chk($sformatf("a_fmt%0d_illegal", i), 64'(a_illegal), 64'(vec[i].ill));
      end
      a_inValid = 0;
      tick;
      chk("a_fmt_drain_outValid", 64'(a_outValid), 64'd0);
      chk("a_fmt_errCount", 64'(a_errCount), 64'd1);

      // ---- B: formats, XLEN 64, streamed back to back ----
      b_outReady = 1;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin
            b_instr = vec[i].instr; b_immSrc = vec[i].src; b_inValid = 1;
         end else begin
            b_inValid = 0;
         end
         #1;
         if (i < 8) chk($sformatf("b_fmt%0d_inReady", i), 64'(b_inReady), 64'd1);
         tick;
         if (i >= 1) begin
            chk($sformatf("b_fmt%0d_outValid", i-1), 64'(b_outValid), 64'd1);
            chk($sformatf("b_fmt%0d_immExt", i-1), b_immExt, vec[i-1].exp64);
            chk($sformatf("b_fmt%0d_illegal", i-1), 64'(b_illegal), 64'(vec[i-1].ill));
         end
      end
      tick;
      chk("b_fmt_drain_outValid", 64'(b_outValid), 64'd0);
      chk("b_fmt_errCount", 64'(b_errCount), 64'd1);

      // ---- B: backpressure, four I-type inputs with outReady low ----
      b_outReady = 0; b_immSrc = 3'd0; b_inValid = 1;
      b_instr = {12'h001, 13'd0}; #1;
      chk("bp_in0_inReady", 64'(b_inReady), 64'd1);
      tick;
      b_instr = {12'h7FF, 13'd0}; #1;
      chk("bp_in1_inReady", 64'(b_inReady), 64'd1);
      tick;
      b_instr = {12'h800, 13'd0}; #1;
      chk("bp_full_inReady", 64'(b_inReady), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("bp_stall%0d_outValid", k), 64'(b_outValid), 64'd1);
         chk($sformatf("bp_stall%0d_immExt", k), b_immExt, bp_exp[0]);
         chk($sformatf("bp_stall%0d_inReady", k), 64'(b_inReady), 64'd0);
      end
      b_outReady = 1; #1;
      chk("bp_release_inReady", 64'(b_inReady), 64'd1);
      tick;
      chk("bp_out1", b_immExt, bp_exp[1]);
      b_instr = {12'hABC, 13'd0};
      tick;
      chk("bp_out2", b_immExt, bp_exp[2]);
      b_inValid = 0;
      tick;
      chk("bp_out3_outValid", 64'(b_outValid), 64'd1);
      chk("bp_out3", b_immExt, bp_exp[3]);
      tick;
      chk("bp_drain_outValid", 64'(b_outValid), 64'd0);

      // ---- B: reset with both stages full (illegal entries) ----
      b_outReady = 0; b_immSrc = 3'd7; b_inValid = 1;
      tick; tick;
      chk("mid_errCount_before", 64'(b_errCount), 64'd3);
      chk("mid_full_inReady", 64'(b_inReady), 64'd0);
      chk("mid_full_outValid", 64'(b_outValid), 64'd1);
      b_reset = 1; b_outReady = 1;
      tick;
      b_reset = 0; b_inValid = 0;
      chk("mid_rst_outValid", 64'(b_outValid), 64'd0);
      chk("mid_rst_errCount", 64'(b_errCount), 64'd0);
      chk("mid_rst_illegal",  64'(b_illegal),  64'd0);
      chk("mid_rst_immExt",   b_immExt,        64'd0);
      chk("mid_rst_inReady",  64'(b_inReady),  64'd1);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk($sformatf("mid_nostale%0d", k), 64'(b_outValid), 64'd0);
      end

      // ---- A: illegal selects and counter saturation ----
      a_reset = 1;
      tick;
      a_reset = 0;
      chk("sat_reset_errCount", 64'(a_errCount), 64'd0);
      exp_cnt = 0;
      a_outReady = 1; a_immSrc = 3'd7; a_inValid = 1;
      for (int i = 0; i < 260; i++) begin
         a_instr = 25'($urandom);
         tick;
         if (exp_cnt < 255) exp_cnt++;
         chk($sformatf("sat%0d_out", i), {a_outValid, a_illegal, a_immExt}, {2'b11, 32'd0});
         chk($sformatf("sat%0d_errCount", i), 64'(a_errCount), 64'(exp_cnt));
      end
      a_inValid = 0;
      tick;
      chk("sat_final_errCount", 64'(a_errCount), 64'd255);

      // ---- throughput: 100 random inputs into both instances ----
      a_outReady = 1; b_outReady = 1;
      for (int i = 0; i < 102; i++) begin
         if (i < 100) begin
            r_instr = 25'($urandom);
            r_src   = 3'($urandom_range(0, 7));
            a_instr = r_instr; a_immSrc = r_src; a_inValid = 1;
            b_instr = r_instr; b_immSrc = r_src; b_inValid = 1;
            qa.push_back(ref_imm(r_instr, r_src, 1'b0));
            qb.push_back(ref_imm(r_instr, r_src, 1'b1));
         end else begin
            a_inValid = 0; b_inValid = 0;
         end
         #1;
         if (i < 100) chk($sformatf("rnd%0d_inReady", i), {a_inReady, b_inReady}, 64'd3);
         tick;
         chk($sformatf("rnd%0d_a_outValid", i), 64'(a_outValid), 64'(i < 100));
         if (a_outValid && qa.size() > 0) begin
            e = qa.pop_front();
            chk($sformatf("rnd%0d_a_data", i), {a_illegal, a_immExt}, {e[64], e[31:0]});
         end
         chk($sformatf("rnd%0d_b_outValid", i), 64'(b_outValid), 64'(i >= 1 && i <= 100));
         if (b_outValid && qb.size() > 0) begin
            e = qb.pop_front();
            chk($sformatf("rnd%0d_b_imm", i), b_immExt, e[63:0]);
            chk($sformatf("rnd%0d_b_ill", i), 64'(b_illegal), 64'(e[64]));
         end
      end
      chk("rnd_a_leftover", 64'(qa.size()), 64'd0);
      chk("rnd_b_leftover", 64'(qb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
